// File: rtl/sd_spi_responder_if.sv
// sd_spi_responder_if: SPI pin bundle between the SoC master and the SD card model
interface sd_spi_responder_if;
  logic spi_clk;
  logic spi_cs;
  logic spi_mosi;
  logic spi_miso;
  logic card_ready;
  logic [5:0] last_cmd;
  modport master(output spi_clk, spi_cs, spi_mosi, input spi_miso, card_ready, last_cmd);
  modport slave(input spi_clk, spi_cs, spi_mosi, output spi_miso, card_ready, last_cmd);
endinterface

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SD-card SPI-mode model answering CMD0/8/55/ACMD41/17 with deterministic data
module sd_spi_responder #(
  parameter int RESP_DELAY = 1,
  parameter int INIT_POLLS = 2,
  parameter int READ_DELAY = 4,
  parameter int BLOCK_BYTES = 512
) (
  input logic CLK,
  input logic RESET,
  sd_spi_responder_if.slave bus
);
  typedef enum logic [3:0] {RX_WAIT, CMD, FILL, R1, R7, RDWAIT, TOKEN, DATA, CRC} state_t;
  localparam logic [15:0] RD = 16'(RESP_DELAY);
  localparam logic [15:0] RDL = 16'(READ_DELAY);
  localparam logic [15:0] BB = 16'(BLOCK_BYTES - 1);
  localparam logic [7:0] NP = 8'(INIT_POLLS);
  state_t state, state_n;
  logic [1:0] sck_s, cs_s, mosi_s;
  logic sck_d, miso, ready, app;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift, out_byte, r1, r1_n, rx_byte, polls, arg;
  logic [15:0] cnt;
  logic [5:0] idx, last;
  logic cs, rise, fall, byte_done, cmd_done, acmd41;
  assign cs = cs_s[1];
  assign rise = sck_s[1] & ~sck_d;
  assign fall = ~sck_s[1] & sck_d;
  assign byte_done = rise & ~cs & (bit_cnt == 3'd7);
  assign rx_byte = {rx_shift[6:0], mosi_s[1]};
  assign cmd_done = byte_done && state == CMD && cnt == 16'd5;
  assign acmd41 = idx == 6'd41 && app;
  assign r1_n = idx == 6'd0 ? 8'h01 :
                (idx == 6'd8 || idx == 6'd55) ? {7'b0, ~ready} :
                acmd41 ? {7'b0, polls < NP} :
                idx == 6'd17 ? (ready ? 8'h00 : 8'h05) :
                (ready ? 8'h04 : 8'h05);
  assign bus.spi_miso = miso;
  assign bus.card_ready = ready;
  assign bus.last_cmd = last;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= RX_WAIT;
    else state <= state_n;
  always_comb begin
    state_n = state;
    out_byte = 8'hFF;
    case (state)
      R1: out_byte = r1;
      R7: out_byte = cnt == 16'd3 ? arg : cnt == 16'd2 ? 8'h01 : 8'h00;
      TOKEN: out_byte = 8'hFE;
      DATA: out_byte = arg + cnt[7:0];
      CRC: out_byte = 8'h00;
      default: out_byte = 8'hFF;
    endcase
    if (cs) state_n = RX_WAIT;
    else if (byte_done)
      case (state)
        RX_WAIT: state_n = rx_byte[7:6] == 2'b01 ? CMD : RX_WAIT;
        CMD: state_n = cnt != 16'd5 ? CMD : RESP_DELAY == 0 ? R1 : FILL;
        FILL: state_n = cnt == 16'd1 ? R1 : FILL;
        R1: state_n = idx == 6'd8 ? R7 : (idx == 6'd17 && r1 == 8'h00) ? (READ_DELAY == 0 ? TOKEN : RDWAIT) : RX_WAIT;
        R7: state_n = cnt == 16'd3 ? RX_WAIT : R7;
        RDWAIT: state_n = cnt == 16'd1 ? TOKEN : RDWAIT;
        TOKEN: state_n = DATA;
        DATA: state_n = cnt == BB ? CRC : DATA;
        CRC: state_n = cnt == 16'd1 ? RX_WAIT : CRC;
        default: state_n = RX_WAIT;
      endcase
  end
  // Shifter: MISO changes on SCK falling edges, a new byte is loaded when bit_cnt is 0
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      sck_s <= 2'b00;
      cs_s <= 2'b11;
      mosi_s <= 2'b00;
      sck_d <= 1'b0;
      bit_cnt <= 3'd0;
      rx_shift <= 8'h00;
      tx_shift <= 8'hFF;
      miso <= 1'b1;
    end else begin
      sck_s <= {sck_s[0], bus.spi_clk};
      cs_s <= {cs_s[0], bus.spi_cs};
      mosi_s <= {mosi_s[0], bus.spi_mosi};
      sck_d <= sck_s[1];
      if (cs) begin
        bit_cnt <= 3'd0;
        tx_shift <= 8'hFF;
        miso <= 1'b1;
      end else begin
        if (rise) begin
          rx_shift <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (fall) begin
          tx_shift <= bit_cnt == 3'd0 ? out_byte : {tx_shift[6:0], 1'b1};
          miso <= bit_cnt == 3'd0 ? out_byte[7] : tx_shift[6];
        end
      end
    end
  // cnt is reloaded on every state change; FILL/RDWAIT count down, the rest count up
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      cnt <= 16'd0;
      arg <= 8'h00;
      idx <= 6'd0;
      r1 <= 8'hFF;
      last <= 6'd0;
      ready <= 1'b0;
      polls <= 8'h00;
      app <= 1'b0;
    end else if (byte_done) begin
      if (state_n != state)
        cnt <= state_n == CMD ? 16'd1 : state_n == FILL ? RD : state_n == RDWAIT ? RDL : 16'd0;
      else
        cnt <= (state == FILL || state == RDWAIT) ? cnt - 16'd1 : cnt + 16'd1;
      if (state == RX_WAIT) idx <= rx_byte[5:0];
      if (state == CMD && cnt == 16'd4) arg <= rx_byte;
      if (cmd_done) begin
        r1 <= r1_n;
        last <= idx;
        app <= idx == 6'd55;
        if (idx == 6'd0) begin
          ready <= 1'b0;
          polls <= 8'h00;
        end else if (acmd41) begin
          if (polls < NP) polls <= polls + 8'h01;
          else ready <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_sd_spi_responder.sv
// tb_sd_spi_responder: directed SD SPI transactions, MISO bytes checked by a scoreboard monitor
module tb_sd_spi_responder;
  localparam int H = 4;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_b, mon_e;
  int mon_n = 0;
  always #5 CLK = ~CLK;
  sd_spi_responder_if sif();
  sd_spi_responder dut(.CLK(CLK), .RESET(RESET), .bus(sif.slave));
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic xfer(input logic [7:0] b, input logic [7:0] e);
    exp_q.push_back(e);
    for (int i = 7; i >= 0; i--) begin
      sif.spi_mosi = b[i];
      repeat (H) @(negedge CLK);
      sif.spi_clk = 1'b1;
      repeat (H) @(negedge CLK);
      sif.spi_clk = 1'b0;
    end
  endtask
  task automatic cmd(input logic [5:0] c, input logic [31:0] a, input logic [7:0] crc, input logic [7:0] r);
    xfer({2'b01, c}, 8'hFF);
    for (int k = 3; k >= 0; k--) xfer(a[8*k +: 8], 8'hFF);
    xfer(crc, 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, r);
  endtask
  task automatic r7(input logic [7:0] echo);
    xfer(8'hFF, 8'h00);
    xfer(8'hFF, 8'h00);
    xfer(8'hFF, 8'h01);
    xfer(8'hFF, echo);
  endtask
  task automatic read_head();
    repeat (4) xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFE);
  endtask
  task automatic init_card();
    for (int p = 0; p < 3; p++) begin
      cmd(6'd55, 32'h0, 8'h65, 8'h01);
      chk("ready_before_acmd41", sif.card_ready, 0);
      cmd(6'd41, 32'h40000000, 8'h77, p == 2 ? 8'h00 : 8'h01);
    end
    chk("ready_after_init", sif.card_ready, 1);
    chk("last_cmd_41", sif.last_cmd, 41);
  endtask
  task automatic cs_low();
    sif.spi_cs = 1'b0;
    repeat (H) @(negedge CLK);
  endtask
  task automatic cs_high();
    repeat (H) @(negedge CLK);
    sif.spi_cs = 1'b1;
    repeat (H) @(negedge CLK);
  endtask
  initial begin
    forever begin
      @(posedge sif.spi_clk);
      if (!sif.spi_cs) begin
        mon_b = {mon_b[6:0], sif.spi_miso};
        mon_n++;
        if (mon_n == 8) begin
          mon_n = 0;
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL miso_byte got %02h with no byte expected", mon_b);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_b !== mon_e) begin
              n_fail++;
              $display("FAIL miso_byte got %02h expected %02h", mon_b, mon_e);
            end
          end
        end
      end
    end
  end
  initial begin
    #3000000;
    $display("FAIL watchdog expired, got no end of test, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    sif.spi_clk = 1'b0;
    sif.spi_cs = 1'b1;
    sif.spi_mosi = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_miso", sif.spi_miso, 1);
    chk("reset_ready", sif.card_ready, 0);
    chk("reset_last_cmd", sif.last_cmd, 0);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    cs_low();
    cmd(6'd0, 32'h0, 8'h95, 8'h01);
    chk("last_cmd_0", sif.last_cmd, 0);
    cmd(6'd17, 32'h0, 8'hFF, 8'h05);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFF);
    chk("last_cmd_17", sif.last_cmd, 17);
    cmd(6'd8, 32'h1AA, 8'h87, 8'h01);
    r7(8'hAA);
    xfer(8'hFF, 8'hFF);
    chk("last_cmd_8", sif.last_cmd, 8);
    init_card();
    cmd(6'd41, 32'h0, 8'hFF, 8'h04);
    cmd(6'd8, 32'h1A5, 8'hFF, 8'h00);
    r7(8'hA5);
    cmd(6'd17, 32'hF0, 8'hFF, 8'h00);
    read_head();
    for (int i = 0; i < 512; i++) xfer(8'hFF, 8'(8'hF0 + i));
    xfer(8'hFF, 8'h00);
    xfer(8'hFF, 8'h00);
    xfer(8'hFF, 8'hFF);
    cmd(6'd17, 32'h10, 8'hFF, 8'h00);
    read_head();
    for (int i = 0; i < 100; i++) xfer(8'hFF, 8'(8'h10 + i));
    cs_high();
    chk("miso_cs_high", sif.spi_miso, 1);
    cs_low();
    chk("miso_after_cs_fall", sif.spi_miso, 1);
    cmd(6'd0, 32'h0, 8'h95, 8'h01);
    chk("ready_cleared_cmd0", sif.card_ready, 0);
    chk("last_cmd_0_after_abort", sif.last_cmd, 0);
    init_card();
    cmd(6'd17, 32'h20, 8'hFF, 8'h00);
    read_head();
    for (int i = 0; i < 10; i++) xfer(8'hFF, 8'(8'h20 + i));
    RESET = 1'b1;
    #1;
    chk("reset_data_miso", sif.spi_miso, 1);
    chk("reset_data_ready", sif.card_ready, 0);
    chk("reset_data_last_cmd", sif.last_cmd, 0);
    @(negedge CLK);
    RESET = 1'b0;
    cs_high();
    cs_low();
    cmd(6'd8, 32'h1AA, 8'h87, 8'h01);
    r7(8'hAA);
    chk("last_cmd_8_after_reset", sif.last_cmd, 8);
    xfer(8'h48, 8'hFF);
    xfer(8'h00, 8'hFF);
    xfer(8'h00, 8'hFF);
    RESET = 1'b1;
    #1;
    chk("reset_cmd_miso", sif.spi_miso, 1);
    chk("reset_cmd_last_cmd", sif.last_cmd, 0);
    @(negedge CLK);
    RESET = 1'b0;
    cs_high();
    cs_low();
    cmd(6'd0, 32'h0, 8'h95, 8'h01);
    cs_high();
    repeat (20) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
